// File: rtl/pipelined_mac_stream.sv
// Three-stage multiply-add / accumulate stream with valid/ready backpressure.
// Stage 1 holds operands, stage 2 holds the extended product and addend, stage 3 is the output register.
module pipelined_mac_stream #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int C_W    = 16,
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [C_W-1:0]   in_c,
  input  logic             in_mode,
  input  logic             in_last,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [OUT_W-1:0] result,
  output logic             result_ovf,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int P_W = A_W + B_W;

  if (OUT_W < P_W || C_W > OUT_W) begin : g_bad_params
    $error("pipelined_mac_stream: requires OUT_W >= A_W+B_W and C_W <= OUT_W");
  end

  // Returns {overflow, value}; the sum is formed one bit wider so the carry/sign is visible.
  function automatic logic [OUT_W:0] add_ovf(input logic [OUT_W-1:0] x, input logic [OUT_W-1:0] y);
    logic [OUT_W:0]   sum;
    logic             ovf;
    logic [OUT_W-1:0] val;
    if (SIGNED) begin
      sum = {x[OUT_W-1], x} + {y[OUT_W-1], y};
      ovf = sum[OUT_W] ^ sum[OUT_W-1];
    end else begin
      sum = {1'b0, x} + {1'b0, y};
      ovf = sum[OUT_W];
    end
    if (SAT && ovf) begin
      if (SIGNED) begin
        val = sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        val = {OUT_W{1'b1}};
      end
    end else begin
      val = sum[OUT_W-1:0];
    end
    return {ovf, val};
  endfunction

  logic             s1_valid_r, s1_mode_r, s1_last_r;
  logic [A_W-1:0]   s1_a_r;
  logic [B_W-1:0]   s1_b_r;
  logic [C_W-1:0]   s1_c_r;
  logic             s2_valid_r, s2_mode_r, s2_last_r;
  logic [OUT_W-1:0] s2_prod_r, s2_c_r;
  logic [OUT_W-1:0] result_r, acc_r;
  logic             result_ovf_r, valid_out_r, acc_ovf_r;

  logic             s3_free_s, s2_adv_s, s2_move_s;
  logic [OUT_W-1:0] prod_ext_s, c_ext_s;
  logic [OUT_W:0]   beat_s, total_s;
  logic             acc_ovf_s;

  assign s3_free_s = !valid_out_r || ready_in;
  assign s2_adv_s  = !s2_valid_r || s3_free_s;
  assign s2_move_s = s2_valid_r && s3_free_s;
  assign ready_out = !s1_valid_r || s2_adv_s;

  if (SIGNED) begin : g_signed
    logic signed [P_W-1:0] sprod_s;
    assign sprod_s    = $signed({{B_W{s1_a_r[A_W-1]}}, s1_a_r}) * $signed({{A_W{s1_b_r[B_W-1]}}, s1_b_r});
    assign prod_ext_s = OUT_W'(sprod_s);
    assign c_ext_s    = OUT_W'($signed(s1_c_r));
  end else begin : g_unsigned
    assign prod_ext_s = OUT_W'({{B_W{1'b0}}, s1_a_r} * {{A_W{1'b0}}, s1_b_r});
    assign c_ext_s    = OUT_W'(s1_c_r);
  end

  assign beat_s    = add_ovf(s2_prod_r, s2_c_r);
  assign total_s   = add_ovf(acc_r, beat_s[OUT_W-1:0]);
  assign acc_ovf_s = acc_ovf_r | beat_s[OUT_W] | total_s[OUT_W];

  // Operand stage: captures a new beat whenever the block is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_a_r     <= {A_W{1'b0}};
      s1_b_r     <= {B_W{1'b0}};
      s1_c_r     <= {C_W{1'b0}};
    end else if (ready_out) begin
      s1_valid_r <= valid_in;
      s1_mode_r  <= in_mode;
      s1_last_r  <= in_last;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_c_r     <= in_c;
    end
  end

  // Product stage: moves forward when empty or when its beat leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_mode_r  <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_prod_r  <= {OUT_W{1'b0}};
      s2_c_r     <= {OUT_W{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_mode_r  <= s1_mode_r;
      s2_last_r  <= s1_last_r;
      s2_prod_r  <= prod_ext_s;
      s2_c_r     <= c_ext_s;
    end
  end

  // Output register and accumulator; an ACC beat without last updates only the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r     <= {OUT_W{1'b0}};
      result_ovf_r <= 1'b0;
      valid_out_r  <= 1'b0;
      acc_r        <= {OUT_W{1'b0}};
      acc_ovf_r    <= 1'b0;
    end else if (s2_move_s) begin
      if (!s2_mode_r) begin
        result_r     <= beat_s[OUT_W-1:0];
        result_ovf_r <= beat_s[OUT_W];
        valid_out_r  <= 1'b1;
      end else if (s2_last_r) begin
        result_r     <= total_s[OUT_W-1:0];
        result_ovf_r <= acc_ovf_s;
        valid_out_r  <= 1'b1;
        acc_r        <= {OUT_W{1'b0}};
        acc_ovf_r    <= 1'b0;
      end else begin
        acc_r        <= total_s[OUT_W-1:0];
        acc_ovf_r    <= acc_ovf_s;
        valid_out_r  <= 1'b0;
      end
    end else if (ready_in) begin
      valid_out_r <= 1'b0;
    end
  end

  assign result     = result_r;
  assign result_ovf = result_ovf_r;
  assign valid_out  = valid_out_r;

endmodule
